pixel_readout: RTL and testbench

- Receive side of the pixel-array read interface; consumes the per-row `read` strobes driven by the pixel state controller.
- For each row strobe, samples the parallel column bus once it has settled and buffers the row in a small FIFO.
- Serializes pixels one per beat onto a valid/ready stream with frame/line markers for the downstream image path.

---
 rtl/pixel_readout_if.sv | 23 ++
 rtl/pixel_readout.sv | 244 ++++++++++++++++++++++++
 tb/tb_pixel_readout.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_if.sv
`default_nettype none
// pixel_readout_if: pixel stream carrying one pixel per beat with frame/line markers.
interface pixel_readout_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_sof;
  logic            out_eol;
  logic            out_eof;

  modport master (
    output out_data, out_valid, out_sof, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sof, out_eol, out_eof,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_readout.sv
`default_nettype none
// +---------------------------------------------------------------------------------+
// | pixel_readout: row-strobe capture, row FIFO and pixel serializer.               |
// | Optional Gray-to-binary pixel decode: PIXEL_READOUT_GRAY_EN.  rev 1.0           |
// +---------------------------------------------------------------------------------+
module pixel_readout #(
  parameter int COL        = 4,
  parameter int ROW        = 4,
  parameter int BITS       = 8,
  parameter int SAMPLE_DLY = 2,
  parameter int DEPTH      = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ROW-1:0]      read,
  input  logic [COL*BITS-1:0] col_data,
  pixel_readout_if.master     stream,
  output logic                overflow,
  output logic                seq_err,
  input  logic                clear_err
);

  localparam int CW   = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int SW   = $clog2(SAMPLE_DLY + 1);

  localparam logic [CW-1:0]   LAST_COL = CW'(COL - 1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROW - 1);
  localparam logic [SW-1:0]   CAP_CNT  = SW'(SAMPLE_DLY - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } cap_state_t;

  function automatic logic is_onehot(input logic [ROW-1:0] v);
    return (v != '0) && ((v & (v - ROW'(1))) == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Strobe register and capture FSM
  // ---------------------------------------------------------------------------
  cap_state_t     state;
  cap_state_t     state_nx;
  logic [ROW-1:0] read_q;
  logic [SW-1:0]  cnt;
  logic [SW-1:0]  cnt_nx;
  logic           read_chg;
  logic           capture;
  logic           proto_err;
  logic [RW-1:0]  row_idx;

  // A change is seen at the edge that loads it into read_q.
  assign read_chg = (read != read_q);

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROW; i++) begin
      if (read_q[i]) row_idx = RW'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      read_q <= read;
      state  <= state_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    proto_err = 1'b0;
    if (read_chg) begin
      cnt_nx = '0;
      if (read == '0) begin
        state_nx = IDLE;
      end else if (is_onehot(read)) begin
        state_nx = SETTLE;
      end else begin
        state_nx  = IDLE;
        proto_err = 1'b1;
      end
      if (state == SETTLE) proto_err = 1'b1;
    end else if (state == SETTLE) begin
      if (cnt == CAP_CNT) begin
        capture  = 1'b1;
        state_nx = WAIT;
      end else begin
        cnt_nx = cnt + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO; the head stays resident until its last column is accepted
  // ---------------------------------------------------------------------------
  logic [COL-1:0][BITS-1:0] row_mem [DEPTH];
  logic [RW-1:0]            idx_mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CNTW-1:0]          count;
  logic [RW-1:0]            exp_row;
  logic                     pop;
  logic                     fifo_full;
  logic                     wr_en;
  logic                     drop;
  logic                     row_bad;

  assign fifo_full = (count == FULL_CNT);
  assign wr_en     = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;
  assign row_bad   = capture && (row_idx != '0) && (row_idx != exp_row);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      row_mem[wr_ptr] <= col_data;
      idx_mem[wr_ptr] <= row_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      exp_row <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + PW'(1);
        exp_row <= (row_idx == LAST_ROW) ? '0 : row_idx + RW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  logic            valid_q;
  logic [BITS-1:0] pix_q;
  logic [CW-1:0]   col_q;
  logic            sof_q;
  logic            eol_q;
  logic            eof_q;
  logic            advance;
  logic            load;
  logic [PW-1:0]   src_ptr;
  logic [CW-1:0]   src_col;

  assign advance = !valid_q || stream.out_ready;
  assign pop     = valid_q && stream.out_ready && (col_q == LAST_COL);

  // Next beat: following column of the head, or column 0 of the row behind it.
  always_comb begin
    src_ptr = rd_ptr;
    src_col = '0;
    load    = 1'b0;
    if (valid_q) begin
      if (col_q == LAST_COL) begin
        src_ptr = rd_ptr + PW'(1);
        load    = (count > CNTW'(1));
      end else begin
        src_col = col_q + CW'(1);
        load    = 1'b1;
      end
    end else begin
      load = (count != '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pix_q   <= '0;
      col_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= load;
      if (load) begin
        pix_q <= row_mem[src_ptr][src_col];
        col_q <= src_col;
        sof_q <= (idx_mem[src_ptr] == '0) && (src_col == '0);
        eol_q <= (src_col == LAST_COL);
        eof_q <= (idx_mem[src_ptr] == LAST_ROW) && (src_col == LAST_COL);
      end
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_sof   = valid_q && sof_q;
  assign stream.out_eol   = valid_q && eol_q;
  assign stream.out_eof   = valid_q && eof_q;

`ifdef PIXEL_READOUT_GRAY_EN
  function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
    logic [BITS-1:0] b;
    b[BITS-1] = g[BITS-1];
    for (int i = BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign stream.out_data = gray2bin(pix_q);
`else
  assign stream.out_data = pix_q;
`endif

  // ---------------------------------------------------------------------------
  // Sticky flags; a new error outranks a simultaneous clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;

      if (proto_err || row_bad) seq_err <= 1'b1;
      else if (clear_err)       seq_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// tb_pixel_readout: scoreboard bench for pixel_readout (honours PIXEL_READOUT_GRAY_EN).
module tb_pixel_readout;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read;
  logic [31:0] col_data;
  logic        clear_err;
  logic        overflow;
  logic        seq_err;

  pixel_readout_if #(.BITS(8)) ifc ();

  pixel_readout #(
    .COL(4), .ROW(4), .BITS(8), .SAMPLE_DLY(2), .DEPTH(4)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .read      (read),
    .col_data  (col_data),
    .stream    (ifc),
    .overflow  (overflow),
    .seq_err   (seq_err),
    .clear_err (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  beat_t q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    beats       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [7:0] v);
`ifdef PIXEL_READOUT_GRAY_EN
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(v >> i);
    return b;
`else
    return v;
`endif
  endfunction

  task automatic push_row(input int row, input logic [31:0] data);
    beat_t b;
    for (int c = 0; c < 4; c++) begin
      b.d   = exp_pix(data[c*8 +: 8]);
      b.sof = (row == 0) && (c == 0);
      b.eol = (c == 3);
      b.eof = (row == 3) && (c == 3);
      q.push_back(b);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_row(input logic [3:0] mask, input int row, input bit cap);
    logic [31:0] d;
    for (int c = 0; c < 4; c++) d[c*8 +: 8] = 8'(16 * row + c);
    read     = mask;
    col_data = d;
    if (cap) push_row(row, d);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && q.size() != 0; i++) cycles(1);
    cycles(2);
    chk("drain", q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    cycles(1);
  endtask

  // Monitor: accepted beats are popped from the scoreboard; stalled beats must show the head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.out_valid && ifc.out_ready) begin
        beats++;
        if (q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("data", ifc.out_data, e.d);
          chk("sof", ifc.out_sof, e.sof);
          chk("eol", ifc.out_eol, e.eol);
          chk("eof", ifc.out_eof, e.eof);
        end
      end else if (ifc.out_valid) begin
        if (q.size() != 0) chk("stall_data", ifc.out_data, q[0].d);
        else               chk("stall_beat", 1, 0);
      end else begin
        chk("mark_idle", {ifc.out_sof, ifc.out_eol, ifc.out_eof}, 3'b000);
      end
    end
  end

  initial begin
    #1_000_000;
    chk("watchdog", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    read          = '0;
    col_data      = '0;
    clear_err     = 1'b0;
    ifc.out_ready = 1'b1;
    cycles(3);
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_data", ifc.out_data, 0);
    chk("rst_marks", {ifc.out_sof, ifc.out_eol, ifc.out_eof}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seq", seq_err, 0);
    rst_n = 1'b1;
    cycles(2);

    // Full frame, back-to-back strobes, with first-row latency
    base = beats;
    set_row(4'b0001, 0, 1);
    cycles(3);
    chk("lat_before", ifc.out_valid, 0);
    cycles(1);
    chk("lat_at", ifc.out_valid, 1);
    cycles(1);
    for (int r = 1; r < 4; r++) begin
      set_row(4'(1 << r), r, 1);
      cycles(5);
    end
    read = '0;
    wait_drain(100);
    chk("frame_beats", beats - base, 16);
    chk("frame_ovf", overflow, 0);
    chk("frame_seq", seq_err, 0);

    // Backpressure: 4 rows fill the FIFO, the 5th is dropped
    base = beats;
    ifc.out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      set_row(4'(1 << r), r, 1);
      cycles(5);
    end
    set_row(4'b0001, 0, 0);
    cycles(5);
    read = '0;
    cycles(3);
    chk("bp_ovf", overflow, 1);
    chk("bp_seq", seq_err, 0);
    chk("bp_valid", ifc.out_valid, 1);
    chk("bp_no_accept", beats - base, 0);
    ifc.out_ready = 1'b1;
    wait_drain(100);
    cycles(10);
    chk("bp_beats", beats - base, 16);
    pulse_clear();
    chk("bp_clear", overflow, 0);

    // Short strobe: abandoned before capture
    base = beats;
    set_row(4'b0010, 1, 0);
    cycles(2);
    read = '0;
    cycles(10);
    chk("short_seq", seq_err, 1);
    chk("short_beats", beats - base, 0);
    pulse_clear();
    chk("short_clear", seq_err, 0);

    // Protocol errors: multi-hot, then row 0 and out-of-order row 2
    base = beats;
    set_row(4'b0011, 0, 0);
    cycles(5);
    read = '0;
    cycles(5);
    chk("mh_seq", seq_err, 1);
    chk("mh_beats", beats - base, 0);
    pulse_clear();
    set_row(4'b0001, 0, 1);
    cycles(5);
    read = '0;
    wait_drain(100);
    chk("row0_seq", seq_err, 0);
    set_row(4'b0100, 2, 1);
    cycles(5);
    read = '0;
    wait_drain(100);
    chk("row2_seq", seq_err, 1);
    chk("order_beats", beats - base, 8);

    // Reset after two beats of row 1
    ifc.out_ready = 1'b0;
    set_row(4'b0001, 0, 1);
    cycles(5);
    set_row(4'b0010, 1, 1);
    cycles(5);
    read = '0;
    cycles(2);
    base = beats;
    ifc.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_beats", beats - base, 6);
    chk("mid_valid", ifc.out_valid, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_seq", seq_err, 0);
    cycles(3);
    rst_n = 1'b1;
    base = beats;
    cycles(20);
    chk("no_residual", beats - base, 0);

    // Nonzero strobe held through reset release counts as a row event
    rst_n = 1'b0;
    set_row(4'b0010, 1, 1);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    read = '0;
    wait_drain(100);
    chk("rel_seq", seq_err, 1);
    pulse_clear();

    // Gray-decode pattern
    read     = 4'b0001;
    col_data = {8'h00, 8'h00, 8'h80, 8'h02};
    push_row(0, col_data);
    cycles(5);
    read = '0;
    wait_drain(100);

    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
